unified_mem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined CPU. It shares one unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store). It serialises accesses through a fixed-latency memory port and returns per-requester valid pulses. It also raises stall signals that the hazard detection unit folds into its stall/flush logic.

---
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory port between fetch and data requests; MEMARB_PERF_EN adds perf counters.
// LATENCY+2 cycles per access (arbitrate, BUSY, RESP); a request is held, with its stall high, until its valid pulse.
module unified_mem_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        dm_stall_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] conflict_cnt_o,
    output logic [31:0] starve_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_LAST  = LATENCY[3:0];
    localparam logic [3:0] STARVE_MX = STARVE_LIMIT[3:0];

    state_t      state, state_nxt;
    logic        owner_dm;
    logic        we_q;
    logic [3:0]  cnt;
    logic [3:0]  starve;
    logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
    logic        both, forced_if, pick_dm, grant, last;

    assign both      = if_req_i & dm_req_i;
    assign forced_if = both && (starve == STARVE_MX);
    assign pick_dm   = dm_req_i & ~forced_if;
    assign grant     = (state == IDLE) && (if_req_i || dm_req_i);
    assign last      = (state == BUSY) && (cnt == LAT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en_o   = (state == BUSY);
        mem_we_o   = (state == BUSY) & we_q;
        if_valid_o = (state == RESP) & ~owner_dm;
        dm_valid_o = (state == RESP) & owner_dm;
    end

    // Starve only grows while a fetch is actually being held off by a data grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= 4'd0;
            starve     <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            if (grant) begin
                owner_dm <= pick_dm;
                we_q     <= pick_dm & dm_we_i;
                addr_q   <= pick_dm ? dm_addr_i : if_addr_i;
                wdata_q  <= pick_dm ? dm_wdata_i : 32'd0;
                cnt      <= 4'd1;
                if (pick_dm && if_req_i) starve <= starve + 4'd1;
                else                     starve <= 4'd0;
            end else if ((state == BUSY) && !last) begin
                cnt <= cnt + 4'd1;
            end
            if (last) begin
                if (owner_dm) dm_rdata_q <= mem_rdata_i;
                else          if_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_stall_o  = if_req_i & ~if_valid_o;
    assign dm_stall_o  = dm_req_i & ~dm_valid_o;

`ifdef MEMARB_PERF_EN
    logic [31:0] conflict_q, starve_evt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_q   <= 32'd0;
            starve_evt_q <= 32'd0;
        end else begin
            if ((state == IDLE) && both) conflict_q   <= conflict_q + 32'd1;
            if (grant && forced_if)      starve_evt_q <= starve_evt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign starve_cnt_o   = starve_evt_q;
`else
    assign conflict_cnt_o = 32'd0;
    assign starve_cnt_o   = 32'd0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scenarios with a completion scoreboard for unified_mem_arbiter (LATENCY=2, STARVE_LIMIT=4).
module tb_unified_mem_arbiter;
    localparam int LAT = 2;
`ifdef MEMARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [31:0] conflict_cnt_o, starve_cnt_o;
    logic        if_valid_o, if_stall_o, dm_valid_o, dm_stall_o, mem_en_o, mem_we_o;

    unified_mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o), .starve_cnt_o(starve_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data follows the address; a store commits on the last BUSY edge.
    logic [31:0] mem [32];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = 5'd0;
    logic [31:0] bd_dat = 32'd0;
    int          en_cyc = 0;
    assign mem_rdata_i = mem[mem_addr_o[6:2]];

    always @(posedge clk) begin
        if (rst_i) begin
            en_cyc <= 0;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_dat;
        end else if (mem_en_o) begin
            if (en_cyc + 1 == LAT) begin
                en_cyc <= 0;
                if (mem_we_o) mem[mem_addr_o[6:2]] <= mem_wdata_o;
            end else begin
                en_cyc <= en_cyc + 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] dat;
        int          cyc;
        bit          chk_dat;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t ei, ed;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (if_valid_o) begin
                if (if_q.size() == 0) chk("if_unexpected_valid", 32'd1, 32'd0);
                else begin
                    ei = if_q.pop_front();
                    chk("if_valid_cycle", 32'(cyc), 32'(ei.cyc));
                    chk("if_rdata", if_rdata_o, ei.dat);
                end
            end
            if (dm_valid_o) begin
                if (dm_q.size() == 0) chk("dm_unexpected_valid", 32'd1, 32'd0);
                else begin
                    ed = dm_q.pop_front();
                    chk("dm_valid_cycle", 32'(cyc), 32'(ed.cyc));
                    if (ed.chk_dat) chk("dm_rdata", dm_rdata_o, ed.dat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] dat);
        bd_we  = 1'b1;
        bd_idx = 5'(idx);
        bd_dat = dat;
        step();
        bd_we  = 1'b0;
    endtask

    task automatic push_if(input logic [31:0] dat, input int c);
        exp_t e;
        e.dat = dat; e.cyc = c; e.chk_dat = 1'b1;
        if_q.push_back(e);
    endtask

    task automatic push_dm(input logic [31:0] dat, input int c, input bit chk_dat);
        exp_t e;
        e.dat = dat; e.cyc = c; e.chk_dat = chk_dat;
        dm_q.push_back(e);
    endtask

    task automatic fetch_only(input logic [31:0] addr, input logic [31:0] dat, input string tag);
        int t0;
        t0 = cyc;
        if_addr_i = addr;
        push_if(dat, t0 + 3);
        for (int k = 0; k < 5; k++) begin
            if_req_i = (k < 4);
            @(negedge clk);
            chk({tag, "_if_stall"}, 32'(if_stall_o), 32'(k < 3));
            chk({tag, "_mem_en"}, 32'(mem_en_o), 32'(k == 1 || k == 2));
            if (k == 1) chk({tag, "_mem_addr"}, mem_addr_o, addr);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'd0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'd0; dm_wdata_i = 32'd0;
        step(); step();
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_valids", 32'({if_valid_o, dm_valid_o}), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        rst_i = 1'b0;
        step();

        // Fetch only
        poke(2, 32'h00A00093);
        fetch_only(32'h8, 32'h00A00093, "fetch");

        // Simultaneous request: DM first, then IF
        poke(2, 32'd10);
        poke(0, 32'h13579BDF);
        t0 = cyc;
        if_addr_i = 32'h0;
        dm_addr_i = 32'h8; dm_we_i = 1'b0;
        push_dm(32'd10, t0 + 3, 1'b1);
        push_if(32'h13579BDF, t0 + 7);
        for (int k = 0; k < 9; k++) begin
            if_req_i = (k < 8);
            dm_req_i = (k < 4);
            @(negedge clk);
            chk("simul_dm_stall", 32'(dm_stall_o), 32'(k < 3));
            chk("simul_if_stall", 32'(if_stall_o), 32'(k < 7));
            if (k == 1) chk("simul_dm_addr", mem_addr_o, 32'h8);
            if (k == 5) chk("simul_if_addr", mem_addr_o, 32'h0);
            step();
        end
        chk("simul_conflict_cnt", conflict_cnt_o, PERF ? 32'd1 : 32'd0);
        chk("simul_starve_cnt", starve_cnt_o, 32'd0);

        // Store
        t0 = cyc;
        dm_we_i = 1'b1; dm_addr_i = 32'h14; dm_wdata_i = 32'h1234;
        push_dm(32'd0, t0 + 3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            dm_req_i = (k < 4);
            @(negedge clk);
            chk("store_mem_we", 32'(mem_we_o), 32'(k == 1 || k == 2));
            chk("store_dm_stall", 32'(dm_stall_o), 32'(k < 3));
            if (k == 1) chk("store_wdata", mem_wdata_o, 32'h1234);
            step();
        end
        dm_we_i = 1'b0;
        chk("store_word5", mem[5], 32'h1234);

        // Starvation: both held continuously
        poke(0, 32'hAAAA0000);
        poke(3, 32'hBBBB0003);
        t0 = cyc;
        if_addr_i = 32'h0; dm_addr_i = 32'hC; dm_we_i = 1'b0;
        for (int g = 0; g < 4; g++) push_dm(32'hBBBB0003, t0 + 3 + 4 * g, 1'b1);
        push_if(32'hAAAA0000, t0 + 19);
        push_dm(32'hBBBB0003, t0 + 23, 1'b1);
        for (int k = 0; k < 26; k++) begin
            if_req_i = (k < 24);
            dm_req_i = (k < 24);
            step();
        end
        chk("starve_starve_cnt", starve_cnt_o, PERF ? 32'd1 : 32'd0);
        chk("starve_conflict_cnt", conflict_cnt_o, PERF ? 32'd7 : 32'd0);

        // Reset during the first BUSY cycle of a store
        poke(6, 32'h0000DEAD);
        dm_we_i = 1'b1; dm_addr_i = 32'h18; dm_wdata_i = 32'h5555; dm_req_i = 1'b1;
        step();
        chk("rstmid_busy", 32'(mem_en_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstmid_mem_en", 32'(mem_en_o), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we_o), 32'd0);
        chk("rstmid_mem_addr", mem_addr_o, 32'd0);
        chk("rstmid_mem_wdata", mem_wdata_o, 32'd0);
        chk("rstmid_dm_rdata", dm_rdata_o, 32'd0);
        chk("rstmid_if_rdata", if_rdata_o, 32'd0);
        chk("rstmid_valids", 32'({if_valid_o, dm_valid_o}), 32'd0);
        chk("rstmid_conflict_cnt", conflict_cnt_o, 32'd0);
        chk("rstmid_starve_cnt", starve_cnt_o, 32'd0);
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        step(); step(); step();
        chk("rstmid_word6", mem[6], 32'h0000DEAD);
        poke(1, 32'hC0DE0001);
        fetch_only(32'h4, 32'hC0DE0001, "postrst");

        step(); step();
        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
